// File: rtl/shift_normalizer16.sv
// shift_normalizer16: iterative leading-one normalizer for 16-bit words.
// It finds how far a word must be shifted left to put its leading 1 at bit 15,
// then returns that shift count (out_shamt) and the shifted word (out_data).
// Inputs and outputs both use valid/ready handshakes, and only one operation
// is in flight at a time.
//
// Handshake semantics: a transfer happens on the rising edge where both valid
// and ready are high. A producer that raises valid holds it, along with its
// data, until the transfer. Ready may depend on state but never on valid.
//
// Optional feature: define NORM_NIBBLE_STEP_EN to let SHIFT skip a whole zero
// nibble per cycle. The results are the same; only the latency is shorter.
module shift_normalizer16 #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SHAMT_W-1:0] out_shamt,
    output logic               out_zero
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic [SHAMT_W-1:0] out_shamt_q, out_shamt_d;
    logic               out_zero_q, out_zero_d;
    logic               accept;

    assign accept = in_valid && in_ready;

    // State register; reset aborts whatever operation is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a zero word skips SHIFT entirely, because it has no leading 1.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = (in_data == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (work_q[WIDTH-1]) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode, taken from the registered state only.
    always_comb begin
        in_ready  = (state_q == S_IDLE) && !rst;
        out_valid = (state_q == S_DONE);
    end

    // Datapath next values. Result registers change only when DONE is entered,
    // so they stay stable while the consumer stalls.
    always_comb begin
        work_d      = work_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_shamt_d = out_shamt_q;
        out_zero_d  = out_zero_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    work_d = in_data;
                    cnt_d  = '0;
                    if (in_data == '0) begin
                        out_data_d  = '0;
                        out_shamt_d = '0;
                        out_zero_d  = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                if (work_q[WIDTH-1]) begin
                    out_data_d  = work_q;
                    out_shamt_d = cnt_q;
                    out_zero_d  = 1'b0;
                end else begin
`ifdef NORM_NIBBLE_STEP_EN
                    // The word is nonzero, so cnt + 4 can never pass 15.
                    if (work_q[WIDTH-1:WIDTH-4] == 4'b0000) begin
                        work_d = {work_q[WIDTH-5:0], 4'b0000};
                        cnt_d  = cnt_q + SHAMT_W'(4);
                    end else begin
                        work_d = {work_q[WIDTH-2:0], 1'b0};
                        cnt_d  = cnt_q + SHAMT_W'(1);
                    end
`else
                    // The word is nonzero, so at most 15 single steps occur.
                    work_d = {work_q[WIDTH-2:0], 1'b0};
                    cnt_d  = cnt_q + SHAMT_W'(1);
`endif
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            work_q      <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_shamt_q <= '0;
            out_zero_q  <= 1'b0;
        end else begin
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_shamt_q <= out_shamt_d;
            out_zero_q  <= out_zero_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_shamt = out_shamt_q;
    assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_shift_normalizer16.sv
// Testbench for shift_normalizer16. It compares the DUT against a behavioural
// leading-zero model and a staged left-shifter model.
module tb_shift_normalizer16;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  out_shamt;
    logic        out_zero;

    int checks;
    int errors;
    logic [20:0] exp_q[$];

    shift_normalizer16 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_shamt (out_shamt),
        .out_zero  (out_zero)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int lzc(input logic [15:0] d);
        int n;
        n = 0;
        for (int i = 15; i >= 0; i--) begin
            if (d[i]) return n;
            n++;
        end
        return 16;
    endfunction

    function automatic int exp_latency(input logic [15:0] d);
        int k;
        if (d == 16'h0000) return 1;
        k = lzc(d);
`ifdef NORM_NIBBLE_STEP_EN
        return 2 + (k / 4) + (k % 4);
`else
        return 2 + k;
`endif
    endfunction

    // Left barrel shifter driven by s0..s3 selects (shift by 1, 2, 4 and 8).
    function automatic logic [15:0] barrel_left(input logic [15:0] d, input logic [3:0] s);
        logic [15:0] v;
        v = d;
        if (s[0]) v = {v[14:0], 1'b0};
        if (s[1]) v = {v[13:0], 2'b0};
        if (s[2]) v = {v[11:0], 4'b0};
        if (s[3]) v = {v[7:0], 8'b0};
        return v;
    endfunction

    function automatic logic [20:0] exp_word(input logic [15:0] d);
        int k;
        logic [31:0] wide;
        if (d == 16'h0000) return {1'b1, 4'd0, 16'h0000};
        k = lzc(d);
        wide = {16'h0000, d} * (32'd1 << k);
        return {1'b0, 4'(k), wide[15:0]};
    endfunction

    // ---------------- driver tasks ----------------
    // Offers d, waits for it to be accepted, then measures the output latency.
    // The result is left pending so the caller decides when to raise out_ready.
    task automatic send_and_wait(input logic [15:0] d, output int lat);
        int w;
        @(posedge clk) #1;
        in_valid = 1'b1;
        in_data  = d;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL accept_timeout data=%h in_ready=%b required=1", d, in_ready);
        end
        @(posedge clk) #1;
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 40);
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL result_timeout data=%h out_valid=%b required=1", d, out_valid);
        end
    endtask

    task automatic consume();
        @(posedge clk) #1;
        out_ready = 1'b1;
        @(posedge clk) #1;
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_data, out_shamt, out_zero} !== 23'd0) begin
            errors++;
            $display("FAIL reset_state got rdy=%b vld=%b data=%h sh=%0d z=%b required all 0",
                     in_ready, out_valid, out_data, out_shamt, out_zero);
        end
        @(posedge clk) #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got %b required 1", in_ready);
        end
    endtask

    // Sends d with no output stall and checks the latency and all result fields.
    task automatic test_directed(input logic [15:0] d);
        int lat;
        logic [20:0] e;
        e = exp_word(d);
        send_and_wait(d, lat);
        checks++;
        if (lat != exp_latency(d)) begin
            errors++;
            $display("FAIL latency data=%h got %0d required %0d", d, lat, exp_latency(d));
        end
        checks++;
        if ({out_zero, out_shamt, out_data} !== e) begin
            errors++;
            $display("FAIL result data=%h got z=%b sh=%0d out=%h required z=%b sh=%0d out=%h",
                     d, out_zero, out_shamt, out_data, e[20], e[19:16], e[15:0]);
        end
        consume();
    endtask

    task automatic test_backpressure();
        int lat;
        send_and_wait(16'h00A3, lat);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (!(out_valid === 1'b1 && out_data === 16'hA300 && out_shamt === 4'd8 &&
                  out_zero === 1'b0 && in_ready === 1'b0)) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d got vld=%b out=%h sh=%0d z=%b rdy=%b required 1 a300 8 0 0",
                         i, out_valid, out_data, out_shamt, out_zero, in_ready);
            end
            @(negedge clk);
        end
        @(posedge clk) #1;
        out_ready = 1'b1;
        @(posedge clk) #1;
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release got vld=%b rdy=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_abort();
        int w;
        int seen;
        @(posedge clk) #1;
        in_valid = 1'b1;
        in_data  = 16'h0004;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk) #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_ready_in_rst got %b required 0", in_ready);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_valid got %b required 0", out_valid);
        end
        @(posedge clk) #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_ready_after got %b required 1", in_ready);
        end
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_no_emit got %0d valid cycles required 0", seen);
        end
        test_directed(16'h4000);
    endtask

    // Random words with random output stalls. Expected results come from exp_q,
    // one entry pushed per send.
    task automatic test_random(input int n);
        int lat;
        int stall;
        logic [15:0] d;
        logic [20:0] e;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 7))
                0:       d = 16'h0000;
                1:       d = 16'h0001 << $urandom_range(0, 15);
                2:       d = 16'($urandom) >> $urandom_range(8, 15);
                default: d = 16'($urandom) >> $urandom_range(0, 15);
            endcase
            exp_q.push_back(exp_word(d));
            send_and_wait(d, lat);
            e = exp_q.pop_front();
            checks++;
            if ({out_zero, out_shamt, out_data} !== e) begin
                errors++;
                $display("FAIL rand_result data=%h got z=%b sh=%0d out=%h required z=%b sh=%0d out=%h",
                         d, out_zero, out_shamt, out_data, e[20], e[19:16], e[15:0]);
            end
            checks++;
            if (lat != exp_latency(d)) begin
                errors++;
                $display("FAIL rand_latency data=%h got %0d required %0d", d, lat, exp_latency(d));
            end
            checks++;
            if (barrel_left(d, out_shamt) !== out_data) begin
                errors++;
                $display("FAIL rand_roundtrip data=%h sh=%0d shifted=%h out=%h",
                         d, out_shamt, barrel_left(d, out_shamt), out_data);
            end
            if (d != 16'h0000) begin
                checks++;
                if (out_data[15] !== 1'b1) begin
                    errors++;
                    $display("FAIL rand_msb data=%h out=%h required bit15=1", d, out_data);
                end
            end
            stall = $urandom_range(0, 2);
            repeat (stall) @(negedge clk);
            consume();
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        out_ready = 1'b0;
        test_reset();
        test_directed(16'h8000);
        test_directed(16'h0001);
        test_directed(16'h0000);
        test_directed(16'h8FFF);
        test_directed(16'h1234);
        test_backpressure();
        test_reset_abort();
        test_random(2000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
